traffic_phase_ctrl: RTL
=======================

// Module: traffic_phase_ctrl
// PURPOSE
// - Intersection phase controller; the consumer/driver side of traffictimer_bh.
// - Sequences two-road lights plus a pedestrian WALK phase.
// - Per phase: loads the timer with the phase duration, restarts it, and advances on its expiry pulse.
// - Watchdog: if the timer never expires, the controller drops into a latched flashing-yellow FAULT.
// PARAMETERS
// - NBITS      32  width of timer_cnt; must match the timer instance.
// - T_GREEN    50  green duration in timer counts, >=1.
// - T_YELLOW   10  yellow duration, >=1.
// - T_ALLRED    5  all-red clearance duration, >=1.
// - T_WALK     40  pedestrian walk duration, >=1.
// - WDOG_LIMIT 255 cycles without timer_expire before FAULT; must be > max(T_*)+2.
// - FLASH_DIV   8  cycles per half-period of the FAULT yellow flash, >=1.
// PORTS
// - clk          in   1      clock, all logic on rising edge.
// - reset        in   1      synchronous, active-low.
// - timer_expire in   1      one-cycle expiry pulse from the timer (timer output).
// - ped_req      in   1      pedestrian button, level, sampled every cycle.
// - timer_rst    out  1      active-high timer restart (drives the timer's reset).
// - timer_cnt    out  NBITS  terminal count for the current phase (drives the timer's cnt_rst).
// - ns_light     out  3      {R,Y,G} one-hot, north-south; 3'b000 = dark (flash off).
// - ew_light     out  3      {R,Y,G} one-hot, east-west.
// - walk         out  1      pedestrian WALK lamp.
// - fault        out  1      watchdog fault, latched until reset.
// BEHAVIOUR
// - Reset (reset==0 at an edge):
//   - state=ALLRED_B; ns/ew=RED (3'b100); walk=0; fault=0.
//   - timer_rst=1; timer_cnt=T_ALLRED; ped_pend=0; watchdog=0; flash=0.
// - States: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK, FAULT.
// - Normal sequence: ALLRED_B -> [WALK if ped_pend] -> NS_GREEN -> NS_YELLOW -> ALLRED_A
//   -> [WALK if ped_pend] -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
//   - WALK exits to the green of the road that follows the all-red it came from; a `from_a` flag records this.
// - Phase entry, all registered, no combinational path to outputs:
//   - timer_rst=1 for exactly the first cycle of the phase; timer_cnt takes the phase duration on that same edge.
//   - timer_cnt is held stable for the whole phase.
// - Advance: on a cycle with timer_rst==0 and timer_expire==1 the FSM moves to the next phase at the next edge.
//   - timer_expire during a timer_rst==1 cycle is ignored.
// - With a conforming timer, a phase of duration D occupies exactly D+2 cycles.
// - Lights per state:
//   - GREEN/YELLOW: the named road is GRN/YEL, the other road RED.
//   - ALLRED and WALK: both roads RED; walk=1 only in WALK.
// - Pedestrian request:
//   - ped_pend is set by ped_req==1 in any state except WALK and FAULT.
//   - ped_pend is cleared on the edge entering WALK; clear wins over a same-cycle set.
// - Watchdog:
//   - Counts cycles since the last timer_rst and clears on timer_rst.
//   - On reaching WDOG_LIMIT it forces FAULT.
// - FAULT:
//   - fault=1; walk=0; timer_rst=1 held.
//   - ns_light=ew_light toggle YEL/dark every FLASH_DIV cycles, starting YEL.
//   - Exit only via reset; timer_expire and ped_req are ignored.
// - Reset mid-phase: reset values appear on the next edge regardless of state; ped_pend is lost.
// - Width: the watchdog counter is $clog2(WDOG_LIMIT+1) bits, saturating, never wraps.
//   - Durations are zero-extended to NBITS.
// STRUCTURE
// - Package traffic_pkg:
//   - state enum/localparams.
//   - light codes RED=3'b100, YEL=3'b010, GRN=3'b001, DARK=3'b000.
// - Sub-module traffic_wdog: watchdog counter plus FAULT flash divider.
//   - Inputs: clk, reset, clr(=timer_rst), en.
//   - Outputs: trip, flash.
// - Top: FSM, ped_pend latch, from_a flag, output registers.
// TESTING (controller wired to a traffictimer_bh instance; T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, WDOG_LIMIT=16, FLASH_DIV=4)
// - Reset held low 3 cycles -> ns=ew=3'b100, timer_rst=1, timer_cnt=1, walk=0, fault=0.
//   - After release: NS_GREEN entered 3 cycles later, timer_cnt=4 on that edge.
// - Free run, ped_req=0:
//   - Phase lengths NS_G 6, NS_Y 4, ALLRED_A 3, EW_G 6, EW_Y 4, ALLRED_B 3 cycles.
//   - Period 26; exactly one road non-red at a time.
// - ped_req pulsed 1 cycle mid NS_GREEN -> after ALLRED_A, WALK for 5 cycles with walk=1 and both RED.
//   - Then EW_GREEN; no second WALK in the following cycle.
// - ped_req held high through WALK:
//   - No re-latch during WALK.
//   - Request on the cycle after WALK exit -> WALK again after the next all-red.
// - timer_expire forced 1 during each timer_rst cycle -> ignored; phase lengths are unchanged.
// - timer_expire tied 0 -> fault=1 16 cycles after the last timer_rst.
//   - Lights go YEL 4 cycles / 3'b000 4 cycles, repeating.
//   - Stays latched until reset=0, then reset values.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes, lamp codes and lamp decode for the phase controller.
package traffic_pkg;

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] ALLRED_A  = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] ALLRED_B  = 3'd5;
    localparam logic [2:0] WALK      = 3'd6;
    localparam logic [2:0] FAULT     = 3'd7;

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    function automatic lamps_t lamps_of(input logic [2:0] st, input logic flash);
        lamps_t l;
        l.ns   = RED;
        l.ew   = RED;
        l.walk = 1'b0;
        case (st)
            NS_GREEN:  l.ns = GRN;
            NS_YELLOW: l.ns = YEL;
            EW_GREEN:  l.ew = GRN;
            EW_YELLOW: l.ew = YEL;
            WALK:      l.walk = 1'b1;
            FAULT: begin
                l.ns = flash ? DARK : YEL;
                l.ew = flash ? DARK : YEL;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: controller <-> phase timer link (restart, terminal count, expiry pulse).
interface traffic_phase_ctrl_if #(parameter int NBITS = 32);
    logic             timer_expire;
    logic             timer_rst;
    logic [NBITS-1:0] timer_cnt;

    modport master (input timer_expire, output timer_rst, output timer_cnt);
    modport slave  (output timer_expire, input timer_rst, input timer_cnt);
endinterface

// File: rtl/traffic_wdog.sv
// traffic_wdog: expiry watchdog and FAULT flash divider for the phase controller.
module traffic_wdog #(
    parameter int WDOG_LIMIT = 255,
    parameter int FLASH_DIV  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic trip,
    output logic flash
);
    localparam int W  = $clog2(WDOG_LIMIT + 1);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [W-1:0]  cnt;
    logic [FW-1:0] fcnt;

    // cnt holds the cycles elapsed since the restart cycle; trip fires on the edge that reaches the limit
    assign trip = !clr && (cnt >= W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            fcnt  <= '0;
            flash <= 1'b0;
        end else begin
            cnt <= clr ? W'(1) : (cnt == W'(WDOG_LIMIT)) ? cnt : cnt + 1'b1;
            if (!en) begin
                fcnt  <= '0;
                flash <= 1'b0;
            end else if (fcnt == FW'(FLASH_DIV - 1)) begin
                fcnt  <= '0;
                flash <= ~flash;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road intersection sequencer with pedestrian WALK and watchdog FAULT.
// Drives an external phase timer through traffic_phase_ctrl_if.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int T_GREEN    = 50,
    parameter int T_YELLOW   = 10,
    parameter int T_ALLRED   = 5,
    parameter int T_WALK     = 40,
    parameter int WDOG_LIMIT = 255,
    parameter int FLASH_DIV  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_ctrl_if.master        tmr,
    input  logic                        ped_req,
    output logic [2:0]                  ns_light,
    output logic [2:0]                  ew_light,
    output logic                        walk,
    output logic                        fault
);
    logic [2:0] state, state_d;
    logic       ped_pend, from_a, trip, flash;

    function automatic logic [NBITS-1:0] dur(input logic [2:0] st);
        return (st == NS_GREEN  || st == EW_GREEN)  ? NBITS'(T_GREEN)  :
               (st == NS_YELLOW || st == EW_YELLOW) ? NBITS'(T_YELLOW) :
               (st == WALK)                         ? NBITS'(T_WALK)   : NBITS'(T_ALLRED);
    endfunction

    traffic_wdog #(.WDOG_LIMIT(WDOG_LIMIT), .FLASH_DIV(FLASH_DIV)) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr.timer_rst),
        .en    (state == FAULT),
        .trip  (trip),
        .flash (flash)
    );

    // expiry seen during the restart cycle belongs to the previous phase and is dropped
    always_comb begin
        state_d = state;
        if (state != FAULT && trip)
            state_d = FAULT;
        else if (state != FAULT && !tmr.timer_rst && tmr.timer_expire)
            case (state)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALLRED_A;
                ALLRED_A:  state_d = ped_pend ? WALK : EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALLRED_B;
                ALLRED_B:  state_d = ped_pend ? WALK : NS_GREEN;
                WALK:      state_d = from_a ? EW_GREEN : NS_GREEN;
                default:   state_d = state;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ALLRED_B;
            tmr.timer_rst <= 1'b1;
            tmr.timer_cnt <= NBITS'(T_ALLRED);
            ped_pend      <= 1'b0;
            from_a        <= 1'b0;
        end else begin
            state         <= state_d;
            tmr.timer_rst <= (state_d != state) || (state_d == FAULT);
            if (state_d != state && state_d != FAULT)
                tmr.timer_cnt <= dur(state_d);
            ped_pend <= (state_d == WALK) ? 1'b0 :
                        ped_pend | (ped_req && state != WALK && state != FAULT);
            if (state == ALLRED_A || state == ALLRED_B)
                from_a <= (state == ALLRED_A);
        end
    end

    always_comb begin
        {ns_light, ew_light, walk} = lamps_of(state, flash);
        fault = (state == FAULT);
    end
endmodule
